// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access sizes and FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    READ_WAIT = 2'b01,
    RESP      = 2'b10
  } dmem_state_e;

  // Counter wide enough for READ_LATENCY-1 with READ_LATENCY up to 4.
  localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic for big-endian (MIPS) accesses: load extraction with
// sign/zero extension and store merging with a lane mask.
// Lane 3 is bits [31:24] (byte offset 0), lane 0 is bits [7:0] (offset 3).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic [3:0]  lane_mask
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] src;

  // Pick the addressed byte/half; offset 0 is the most significant lane.
  always_comb begin
    byte_sel = word[{~offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected byte/half; word loads pass through unchanged.
  always_comb begin
    load_val = word;
    case (size)
      SIZE_BYTE: load_val = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_val = {{16{is_signed & half_sel[15]}}, half_sel};
      default:   load_val = word;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed ones.
  always_comb begin
    lane_mask = 4'b0000;
    src       = wdata;
    case (size)
      SIZE_BYTE: begin
        lane_mask = 4'b1000 >> offset;
        src       = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane_mask = offset[1] ? 4'b0011 : 4'b1100;
        src       = {2{wdata[15:0]}};
      end
      SIZE_WORD: begin
        lane_mask = 4'b1111;
        src       = wdata;
      end
      default: begin
        lane_mask = 4'b0000;
        src       = wdata;
      end
    endcase
  end

  // Merge: enabled lanes take new data, the rest keep the old word.
  always_comb begin
    store_word = word;
    for (int i = 0; i < 4; i++) begin
      store_word[8*i +: 8] = lane_mask[i] ? src[8*i +: 8] : word[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word array behind a valid/ready request port with
// byte/half/word accesses, configurable read latency and error reporting.
// Optional macro DMEM_ALIGN_CHECK_EN: when defined, misaligned half/word
// accesses report an error; otherwise the low address bits are forced to 0.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high in IDLE and RESP (never during reset); resp_valid is a
// one-cycle pulse carrying the response of the single outstanding request.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_MEM_SIZE = 32,
  parameter int READ_LATENCY  = 1,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  busy,
  output dmem_state_e           dbg_state
);

  localparam int IDX_W = $clog2(DATA_MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * DATA_MEM_SIZE);

  logic [31:0] mem [DATA_MEM_SIZE];

  dmem_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       eff_off;
  logic             in_range;
  logic             misaligned;
  logic             req_err;
  logic [31:0]      load_val;
  logic [31:0]      store_word;
  logic [3:0]       lane_mask;

  assign req_ready = !reset && (state == IDLE || state == RESP);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[IDX_W+1:2];

  // Range, size and alignment checks; also the effective lane offset.
  always_comb begin
    in_range = ({1'b0, req_addr} < MEM_BYTES);
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = (req_size == SIZE_HALF && req_addr[0]) ||
                 (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
    eff_off    = req_addr[1:0];
`else
    misaligned = 1'b0;
    eff_off    = req_addr[1:0];
    if (req_size == SIZE_HALF) eff_off = {req_addr[1], 1'b0};
    if (req_size == SIZE_WORD) eff_off = 2'b00;
`endif
    req_err = !in_range || (req_size == SIZE_RSVD) || misaligned;
  end

  dmem_lane_align u_align (
    .word       (mem[word_idx]),
    .offset     (eff_off),
    .size       (req_size),
    .is_signed  (req_signed),
    .wdata      (req_wdata),
    .load_val   (load_val),
    .store_word (store_word),
    .lane_mask  (lane_mask)
  );

  // Storage: stores commit on the accepting edge; never cleared by reset.
  always_ff @(posedge clock) begin
    if (accept && req_write && !req_err && (|lane_mask)) begin
      mem[word_idx] <= store_word;
    end
  end

  // State register plus the response captured at acceptance, so a later
  // store cannot alter data for a load already in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        rdata_q <= (req_write || req_err) ? 32'h0 : load_val;
        err_q   <= req_err;
      end
    end
  end

  // Next state: stores and single-cycle loads go straight to RESP; longer
  // loads wait in READ_WAIT while the counter runs down to 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, RESP: begin
        if (state == RESP) state_n = IDLE;
        if (accept) begin
          if (req_write || READ_LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = READ_WAIT;
            cnt_n   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      READ_WAIT: begin
        if (cnt <= CNT_W'(1)) state_n = RESP;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP) && !reset;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_error = resp_valid && err_q;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances at read latencies 1, 3 and 4 sharing
// one clock and reset, driven with directed vectors.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid  [3];
  logic        req_write  [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [1:0]  req_size   [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_error [3];
  logic        busy       [3];
  logic [31:0] resp_rdata [3];
  dmem_state_e dbg_state  [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_MEM_SIZE(32), .READ_LATENCY(1), .ADDR_WIDTH(32)) u_l1 (
    .clock(clk), .reset(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_signed(req_signed[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .busy(busy[0]),
    .dbg_state(dbg_state[0]));

  dmem_ctrl #(.DATA_MEM_SIZE(32), .READ_LATENCY(3), .ADDR_WIDTH(32)) u_l3 (
    .clock(clk), .reset(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_signed(req_signed[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .busy(busy[1]),
    .dbg_state(dbg_state[1]));

  dmem_ctrl #(.DATA_MEM_SIZE(32), .READ_LATENCY(4), .ADDR_WIDTH(32)) u_l4 (
    .clock(clk), .reset(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_size(req_size[2]),
    .req_signed(req_signed[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]), .busy(busy[2]),
    .dbg_state(dbg_state[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, starting and ending at a negedge.
  task automatic access(input int d, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input string tag);
    int n;
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_size[d]   = size;
    req_signed[d] = sgn;
    req_wdata[d]  = wdata;
    check({tag, ".rdy"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'hxxxx_xxxx;
    n = 1;
    while (!resp_valid[d] && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".rd"}, resp_rdata[d], exp_rd);
    check({tag, ".err"}, 32'(resp_error[d]), 32'(exp_err));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_signed[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_size[d] = 2'b10;
    end

    // Reset block
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d.rdy", d), 32'(req_ready[d]), 32'd0);
      check($sformatf("rst%0d.vld", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("rst%0d.busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst%0d.rd", d), resp_rdata[d], 32'd0);
      check($sformatf("rst%0d.err", d), 32'(resp_error[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("post_rst%0d.rdy", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("post_rst%0d.state", d), 32'(dbg_state[d]), 32'(IDLE));
    end

    // Basic word store/load at latency 1
    access(0, 1, 32'h40, 2'b10, 0, 32'h0000000C, 32'h0, 0, 1, "sw40");
    access(0, 0, 32'h40, 2'b10, 0, 32'h0, 32'h0000000C, 0, 1, "lw40");
    check("mem16", u_l1.mem[16], 32'd12);

    // Big-endian byte/half loads with extension at latency 3
    access(1, 1, 32'h0, 2'b10, 0, 32'h80FF7F01, 32'h0, 0, 1, "l3.sw0");
    access(1, 0, 32'h0, 2'b00, 1, 32'h0, 32'hFFFFFF80, 0, 3, "lb0");
    access(1, 0, 32'h1, 2'b00, 0, 32'h0, 32'h000000FF, 0, 3, "lbu1");
    access(1, 0, 32'h1, 2'b00, 1, 32'h0, 32'hFFFFFFFF, 0, 3, "lb1");
    access(1, 0, 32'h2, 2'b00, 1, 32'h0, 32'h0000007F, 0, 3, "lb2");
    access(1, 0, 32'h2, 2'b01, 1, 32'h0, 32'h00007F01, 0, 3, "lh2");
    access(1, 0, 32'h0, 2'b01, 1, 32'h0, 32'hFFFF80FF, 0, 3, "lh0");
    access(1, 0, 32'h0, 2'b01, 0, 32'h0, 32'h000080FF, 0, 3, "lhu0");
    access(1, 0, 32'h0, 2'b10, 1, 32'h0, 32'h80FF7F01, 0, 3, "l3.lw0");

    // Partial stores touch only their lanes
    access(0, 1, 32'h4, 2'b10, 0, 32'h11223344, 32'h0, 0, 1, "sw4");
    access(0, 1, 32'h5, 2'b00, 0, 32'hFFFFFFAA, 32'h0, 0, 1, "sb5");
    access(0, 0, 32'h4, 2'b10, 0, 32'h0, 32'h11AA3344, 0, 1, "lw4.a");
    access(0, 1, 32'h6, 2'b01, 0, 32'h1234BEEF, 32'h0, 0, 1, "sh6");
    access(0, 0, 32'h4, 2'b10, 0, 32'h0, 32'h11AABEEF, 0, 1, "lw4.b");

    // Range boundary and reserved size
    access(0, 1, 32'h0, 2'b10, 0, 32'h01020304, 32'h0, 0, 1, "sw0");
    access(0, 1, 32'h7C, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0, 1, "sw7c");
    access(0, 0, 32'h7C, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 1, "lw7c");
    access(0, 1, 32'h80, 2'b10, 0, 32'hDEADBEEF, 32'h0, 1, 1, "sw80");
    access(0, 0, 32'h80, 2'b10, 0, 32'h0, 32'h0, 1, 1, "lw80");
    access(0, 0, 32'hFFFFFFFC, 2'b10, 0, 32'h0, 32'h0, 1, 1, "lwtop");
    access(0, 0, 32'h0, 2'b10, 0, 32'h0, 32'h01020304, 0, 1, "lw0.nowrap");
    check("mem0", u_l1.mem[0], 32'h01020304);
    access(0, 1, 32'h4, 2'b11, 0, 32'h0, 32'h0, 1, 1, "srsvd");
    access(0, 0, 32'h4, 2'b11, 0, 32'h0, 32'h0, 1, 1, "lrsvd");
    access(0, 0, 32'h4, 2'b10, 0, 32'h0, 32'h11AABEEF, 0, 1, "lw4.c");
    access(1, 0, 32'h80, 2'b10, 0, 32'h0, 32'h0, 1, 3, "l3.lw80");

    // Misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 0, 32'h3, 2'b10, 0, 32'h0, 32'h0, 1, 1, "lw3");
    access(0, 0, 32'h1, 2'b01, 1, 32'h0, 32'h0, 1, 1, "lh1");
    access(0, 0, 32'h3, 2'b01, 0, 32'h0, 32'h0, 1, 1, "lh3");
`else
    access(0, 0, 32'h3, 2'b10, 0, 32'h0, 32'h01020304, 0, 1, "lw3");
    access(0, 0, 32'h1, 2'b01, 1, 32'h0, 32'h00000102, 0, 1, "lh1");
    access(0, 0, 32'h3, 2'b01, 0, 32'h0, 32'h00000304, 0, 1, "lh3");
`endif

    // Back-to-back loads with req_valid held high
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'b10; req_signed[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin req_addr[0] = 32'h0;  exp_q.push_back(32'h01020304); end
        1: begin req_addr[0] = 32'h4;  exp_q.push_back(32'h11AABEEF); end
        2: begin req_addr[0] = 32'h40; exp_q.push_back(32'h0000000C); end
        default: begin req_addr[0] = 32'h7C; exp_q.push_back(32'hCAFEF00D); end
      endcase
      check($sformatf("b2b%0d.rdy", i), 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d.vld", i), 32'(resp_valid[0]), 32'd1);
      check($sformatf("b2b%0d.rd", i), resp_rdata[0], exp_q.pop_front());
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("b2b.end", 32'(resp_valid[0]), 32'd0);

    // Latency 4: normal load, then reset in flight
    access(2, 1, 32'h8, 2'b10, 0, 32'h55AA55AA, 32'h0, 0, 1, "l4.sw8");
    access(2, 0, 32'h8, 2'b10, 0, 32'h0, 32'h55AA55AA, 0, 4, "l4.lw8");

    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h8; req_size[2] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("l4.busy", 32'(busy[2]), 32'd1);
    check("l4.state", 32'(dbg_state[2]), 32'(READ_WAIT));
    rst = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid[2]) pulses++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[2]) pulses++;
    end
    check("l4.drop", 32'(pulses), 32'd0);
    check("l4.rdy", 32'(req_ready[2]), 32'd1);
    check("l4.idle", 32'(busy[2]), 32'd0);

    // Store accepted right before reset stays committed, and its ack is dropped
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'hC;
    req_size[2] = 2'b10; req_wdata[2] = 32'h13579BDF;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("l4.st_rst_vld", 32'(resp_valid[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(2, 0, 32'hC, 2'b10, 0, 32'h0, 32'h13579BDF, 0, 4, "l4.lwc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
